// File: rtl/div_pkg.sv
// -----------------------------------------------------------------------------
// div_pkg: shared definitions for the memory-mapped iterative divider.
//   - register word addresses on the reg_* interface
//   - CTRL / STATUS bit positions
//   - divider FSM state encoding
//   - divide-by-zero quotient constant
//   - byte-enable merge helper for register writes
// Optional build macro used by the importing files: DIV_SIGNED_EN.
// -----------------------------------------------------------------------------
package div_pkg;

  localparam logic [3:0] ADDR_DIVIDEND = 4'h0;
  localparam logic [3:0] ADDR_DIVISOR  = 4'h1;
  localparam logic [3:0] ADDR_CTRL     = 4'h2;
  localparam logic [3:0] ADDR_STATUS   = 4'h3;
  localparam logic [3:0] ADDR_QUOT     = 4'h4;
  localparam logic [3:0] ADDR_REM      = 4'h5;

  localparam int CTRL_START  = 0;
  localparam int CTRL_SIGNED = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY = 0;
  localparam int STATUS_DONE = 1;
  localparam int STATUS_DZ   = 2;

  localparam logic [31:0] DZ_QUOT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_e;

  // Merge a 32-bit write into an existing register, one byte lane per enable.
  function automatic logic [31:0] apply_be(input logic [31:0] old_v,
                                           input logic [31:0] new_v,
                                           input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/div_core.sv
// -----------------------------------------------------------------------------
// div_core: radix-2 restoring shift-subtract divider, one quotient bit per clk.
//   clk, rst_n    : clock, synchronous active-low reset
//   start_i       : start request (ignored unless idle)
//   signed_i      : treat operands as two's complement (sampled with start_i)
//   dividend_i    : dividend, latched on an accepted start
//   divisor_i     : divisor, latched on an accepted start
//   busy_o        : operation in progress (CALC or FIN)
//   fin_o         : high during the FIN cycle; results land at the end of it
//   dz_o          : last operation was a divide by zero
//   quot_o, rem_o : registered results, updated at the end of FIN
// With signed_i=0 the sign path is idle, so callers that never enable signed
// mode (DIV_SIGNED_EN undefined in div_regs) get a plain unsigned divider.
// -----------------------------------------------------------------------------
module div_core
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             fin_o,
  output logic             dz_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o
);

  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH:0]     rem_q;     // extra bit exposes the subtract borrow
  logic [WIDTH-1:0]   quo_q;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0]   dsr_q;
  logic               qneg_q;
  logic               rneg_q;
  logic               dz_q;
  logic [WIDTH-1:0]   quot_q;
  logic [WIDTH-1:0]   remo_q;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  // Partial remainder < divisor always, so the shift never loses a set bit;
  // rem_diff[WIDTH]=1 means the trial subtract borrowed and is discarded.
  // NOTE: every always_comb output gets a default/unconditional assignment
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    rem_shift = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, dsr_q};
    a_neg     = signed_i & dividend_i[WIDTH-1];
    b_neg     = signed_i & divisor_i[WIDTH-1];
    a_mag     = a_neg ? -dividend_i : dividend_i;
    b_mag     = b_neg ? -divisor_i  : divisor_i;
    q_fix     = qneg_q ? -quo_q : quo_q;
    r_fix     = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dsr_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      remo_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            dsr_q  <= b_mag;
            qneg_q <= a_neg ^ b_neg;
            rneg_q <= a_neg;
            if (divisor_i == '0) begin
              // Keep the raw dividend: it is returned verbatim as REM.
              dz_q    <= 1'b1;
              quo_q   <= dividend_i;
              state_q <= FIN;
            end else begin
              dz_q    <= 1'b0;
              quo_q   <= a_mag;
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= rem_diff[WIDTH] ? rem_shift : rem_diff;
          quo_q   <= {quo_q[WIDTH-2:0], ~rem_diff[WIDTH]};
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ITER - 1)) state_q <= FIN;
        end
        FIN: begin
          if (dz_q) begin
            quot_q <= WIDTH'(DZ_QUOT);
            remo_q <= quo_q;
          end else begin
            quot_q <= q_fix;
            remo_q <= r_fix;
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign fin_o  = (state_q == FIN);
  assign dz_o   = dz_q;
  assign quot_o = quot_q;
  assign rem_o  = remo_q;

endmodule

// File: rtl/div_regs.sv
// -----------------------------------------------------------------------------
// div_regs: memory-mapped divider peripheral on the reg_* register interface.
//   clk, rst_n : clock, synchronous active-low reset
//   reg_wr     : write strobe           reg_rd    : read strobe
//   reg_byte   : write byte enables     reg_addr  : word address
//   reg_wdata  : write data             reg_rdata : registered read data
//   irq        : level interrupt = STATUS.DONE & CTRL.IRQ_EN
// Map: 0 DIVIDEND, 1 DIVISOR, 2 CTRL{IRQ_EN,SIGNED,START}, 3 STATUS{DZ,DONE,
// BUSY}, 4 QUOT, 5 REM, others read 0.
// Build macro DIV_SIGNED_EN implements CTRL.SIGNED; otherwise it reads 0 and
// every operation is unsigned.
// -----------------------------------------------------------------------------
module div_regs
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = WIDTH
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reg_wr,
  input  logic        reg_rd,
  input  logic [3:0]  reg_byte,
  input  logic [3:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  output logic        irq
);

  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH-1:0] divisor_q;
  logic             irq_en_q;
  logic             done_q;
  logic             dz_q;
  logic [31:0]      rdata_q;
  logic [31:0]      rdata_d;
  logic             signed_en;

  logic             core_busy;
  logic             core_fin;
  logic             core_dz;
  logic [WIDTH-1:0] core_quot;
  logic [WIDTH-1:0] core_rem;

  logic             start_wr;
  logic             start_acc;
  logic             status_clr;

  // START is a byte-0 write pulse; it only counts when the core is idle.
  assign start_wr   = reg_wr && (reg_addr == ADDR_CTRL) && reg_byte[0]
                      && reg_wdata[CTRL_START];
  assign start_acc  = start_wr && !core_busy;
  assign status_clr = reg_wr && (reg_addr == ADDR_STATUS) && reg_byte[0]
                      && reg_wdata[STATUS_DONE];

`ifdef DIV_SIGNED_EN
  logic signed_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      signed_q <= 1'b0;
    end else if (reg_wr && (reg_addr == ADDR_CTRL) && reg_byte[0]) begin
      signed_q <= reg_wdata[CTRL_SIGNED];
    end
  end

  assign signed_en = signed_q;
`else
  assign signed_en = 1'b0;
`endif

  div_core #(
    .WIDTH (WIDTH),
    .ITER  (ITER)
  ) u_core (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_acc),
    .signed_i   (signed_en),
    .dividend_i (dividend_q),
    .divisor_i  (divisor_q),
    .busy_o     (core_busy),
    .fin_o      (core_fin),
    .dz_o       (core_dz),
    .quot_o     (core_quot),
    .rem_o      (core_rem)
  );

  // Read mux works on pre-edge register values, so a read that coincides
  // with a write returns the old contents.
  always_comb begin
    rdata_d = '0;
    case (reg_addr)
      ADDR_DIVIDEND: rdata_d = 32'(dividend_q);
      ADDR_DIVISOR:  rdata_d = 32'(divisor_q);
      ADDR_CTRL: begin
        rdata_d[CTRL_IRQ_EN] = irq_en_q;
        rdata_d[CTRL_SIGNED] = signed_en;
      end
      ADDR_STATUS: begin
        rdata_d[STATUS_BUSY] = core_busy;
        rdata_d[STATUS_DONE] = done_q;
        rdata_d[STATUS_DZ]   = dz_q;
      end
      ADDR_QUOT:     rdata_d = 32'(core_quot);
      ADDR_REM:      rdata_d = 32'(core_rem);
      default:       rdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dividend_q <= '0;
      divisor_q  <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (reg_wr) begin
        case (reg_addr)
          ADDR_DIVIDEND: dividend_q <= WIDTH'(apply_be(32'(dividend_q), reg_wdata, reg_byte));
          ADDR_DIVISOR:  divisor_q  <= WIDTH'(apply_be(32'(divisor_q), reg_wdata, reg_byte));
          ADDR_CTRL:     if (reg_byte[0]) irq_en_q <= reg_wdata[CTRL_IRQ_EN];
          default: ;
        endcase
      end

      // Completion outranks a same-cycle clear; a new start clears both flags.
      if (core_fin) begin
        done_q <= 1'b1;
        dz_q   <= core_dz;
      end else if (status_clr || start_acc) begin
        done_q <= 1'b0;
        dz_q   <= 1'b0;
      end

      if (reg_rd) rdata_q <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq       = done_q & irq_en_q;

endmodule

// File: tb/tb_div_regs.sv
// -----------------------------------------------------------------------------
// tb_div_regs: self-checking bench for div_regs. Expected quotient/remainder
// pairs are queued when an operation is started and compared when the result
// registers are read back. Inputs change on the falling edge, outputs are
// sampled 1ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_div_regs;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_wr = 1'b0;
  logic        reg_rd = 1'b0;
  logic [3:0]  reg_byte = 4'h0;
  logic [3:0]  reg_addr = 4'h0;
  logic [31:0] reg_wdata = 32'h0;
  logic [31:0] reg_rdata;
  logic        irq;

  typedef struct packed {
    logic [31:0] quot;
    logic [31:0] rem;
  } result_t;

  result_t exp_q[$];
  int      n_cmp = 0;
  int      n_err = 0;

  always #5 clk = ~clk;

  div_regs dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .reg_wr    (reg_wr),
    .reg_rd    (reg_rd),
    .reg_byte  (reg_byte),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq       (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference arithmetic on magnitudes; avoids the native signed-divide
  // overflow case (most-negative / -1).
  function automatic result_t model(input logic [31:0] a, input logic [31:0] b,
                                    input logic sgn);
    result_t     res;
    logic        an, bn;
    logic [31:0] ma, mb;
    if (b == 32'h0) begin
      res.quot = 32'hFFFF_FFFF;
      res.rem  = a;
    end else begin
      an = sgn & a[31];
      bn = sgn & b[31];
      ma = an ? -a : a;
      mb = bn ? -b : b;
      res.quot = ma / mb;
      res.rem  = ma % mb;
      if (an ^ bn) res.quot = -res.quot;
      if (an)      res.rem  = -res.rem;
    end
    return res;
  endfunction

  // Each bus task consumes exactly one rising edge.
  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be = 4'hF);
    @(negedge clk);
    reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_byte = be;
    @(posedge clk); #1;
    reg_wr = 1'b0; reg_byte = 4'h0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    reg_rd = 1'b1; reg_addr = a;
    @(posedge clk); #1;
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ctrl);
    logic sgn;
`ifdef DIV_SIGNED_EN
    sgn = ctrl[CTRL_SIGNED];
`else
    sgn = 1'b0;
`endif
    wr(ADDR_DIVIDEND, a);
    wr(ADDR_DIVISOR, b);
    exp_q.push_back(model(a, b, sgn));
    wr(ADDR_CTRL, ctrl | 32'h1);
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] st;
    int n;
    st = 32'h0;
    n  = 0;
    while (!st[STATUS_DONE] && n < 80) begin
      rd(ADDR_STATUS, st);
      n++;
    end
    if (!st[STATUS_DONE]) check({tag, "_timeout"}, st & 32'h2, 32'h2);
  endtask

  task automatic collect(input string tag);
    result_t     e;
    logic [31:0] v;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 32'(exp_q.size()), 32'h1);
    end else begin
      e = exp_q.pop_front();
      rd(ADDR_QUOT, v);
      check({tag, "_quot"}, v, e.quot);
      rd(ADDR_REM, v);
      check({tag, "_rem"}, v, e.rem);
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ctrl);
    start_op(a, b, ctrl);
    wait_done(tag);
    collect(tag);
    wr(ADDR_STATUS, 32'h2);
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] v;
    for (int i = 0; i < 6; i++) begin
      rd(4'(i), v);
      check($sformatf("%s_reg%0d", tag, i), v, 32'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] ra, rb;

    // ---- reset state ----
    tick(3);
    check("rst_rdata", reg_rdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    check_all_zero("rst");

    // ---- 100/7 with exact BUSY/DONE/irq timing ----
    wr(ADDR_DIVIDEND, 32'd100);
    wr(ADDR_DIVISOR, 32'd7);
    exp_q.push_back(model(32'd100, 32'd7, 1'b0));
    wr(ADDR_CTRL, 32'h5);                       // edge N: START + IRQ_EN
    for (int i = 0; i < 33; i++) begin          // reads at N+1..N+33 see N..N+32
      rd(ADDR_STATUS, v);
      check($sformatf("busy_win_%0d", i), v, 32'h1);
      if (i == 31) check("irq_pre", 32'(irq), 32'h0);
    end
    check("irq_done", 32'(irq), 32'h1);         // just after edge N+33
    rd(ADDR_STATUS, v);
    check("status_done", v, 32'h2);
    collect("u100_7");
    rd(ADDR_CTRL, v);
    check("ctrl_rb", v, 32'h4);
    wr(ADDR_STATUS, 32'h2);
    rd(ADDR_STATUS, v);
    check("done_clr", v, 32'h0);
    check("irq_clr", 32'(irq), 32'h0);

    // ---- more unsigned patterns ----
    wr(ADDR_CTRL, 32'h0);
    run_op("u_max_1",   32'hFFFF_FFFF, 32'h1,         32'h0);
    run_op("u_small",   32'd5,         32'd10,        32'h0);
    run_op("u_max_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    run_op("u_beef",    32'hDEAD_BEEF, 32'h10,        32'h0);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 32'h0) rb = 32'd3;
      run_op($sformatf("u_rand%0d", i), ra, rb, 32'h0);
    end

    // ---- divide by zero ----
    wr(ADDR_DIVIDEND, 32'h1234);
    wr(ADDR_DIVISOR, 32'h0);
    exp_q.push_back(model(32'h1234, 32'h0, 1'b0));
    wr(ADDR_CTRL, 32'h1);                       // edge N, IRQ_EN=0
    rd(ADDR_STATUS, v);                         // state after N
    check("dz_pre_done", v & 32'h2, 32'h0);
    rd(ADDR_STATUS, v);                         // state after N+1
    check("dz_status", v, 32'h6);
    check("dz_irq_off", 32'(irq), 32'h0);
    collect("dz");
    wr(ADDR_STATUS, 32'h2);
    rd(ADDR_STATUS, v);
    check("dz_clr", v, 32'h0);

    // ---- byte enables, unmapped addresses, gated START ----
    wr(ADDR_DIVIDEND, 32'h0);
    wr(ADDR_DIVIDEND, 32'hAABB_CCDD, 4'b0010);
    rd(ADDR_DIVIDEND, v);
    check("be_dividend", v, 32'h0000_CC00);
    wr(ADDR_DIVISOR, 32'h1122_3344);
    wr(ADDR_DIVISOR, 32'hAABB_CCDD, 4'b1001);
    rd(ADDR_DIVISOR, v);
    check("be_divisor", v, 32'hAA22_33DD);
    wr(4'h7, 32'hFFFF_FFFF);
    rd(4'h7, v);
    check("unmapped7", v, 32'h0);
    rd(4'h6, v);
    check("unmapped6", v, 32'h0);
    wr(ADDR_CTRL, 32'h1, 4'b0010);
    rd(ADDR_STATUS, v);
    check("start_no_be0", v, 32'h0);

    // ---- START while busy is ignored ----
    wr(ADDR_DIVIDEND, 32'd1000);
    wr(ADDR_DIVISOR, 32'd3);
    exp_q.push_back(model(32'd1000, 32'd3, 1'b0));
    wr(ADDR_CTRL, 32'h5);                       // edge N
    tick(4);
    wr(ADDR_DIVISOR, 32'd1);                    // N+5
    wr(ADDR_CTRL, 32'h5);                       // N+6, ignored
    tick(26);                                   // N+32
    check("busy_irq_pre", 32'(irq), 32'h0);
    tick(1);                                    // N+33
    check("busy_irq_done", 32'(irq), 32'h1);
    collect("busy_restart");
    rd(ADDR_DIVISOR, v);
    check("busy_divisor_rb", v, 32'd1);
    wr(ADDR_STATUS, 32'h2);
    tick(40);
    rd(ADDR_STATUS, v);
    check("busy_single_done", v, 32'h0);

    // ---- signed mode ----
`ifdef DIV_SIGNED_EN
    run_op("s_m7_2",     32'hFFFF_FFF9, 32'd2,         32'h2);
    run_op("s_min_m1",   32'h8000_0000, 32'hFFFF_FFFF, 32'h2);
    run_op("s_7_m2",     32'd7,         32'hFFFF_FFFE, 32'h2);
    run_op("s_m7_m2",    32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'h2);
    run_op("s_dz",       32'h8000_0005, 32'h0,         32'h2);
    rd(ADDR_CTRL, v);
    check("s_ctrl_rb", v, 32'h2);
    wr(ADDR_CTRL, 32'h0);
`else
    wr(ADDR_CTRL, 32'h2);
    rd(ADDR_CTRL, v);
    check("nosigned_ctrl_rb", v, 32'h0);
    run_op("nosigned_op", 32'hFFFF_FFF9, 32'd2, 32'h2);
    wr(ADDR_CTRL, 32'h0);
`endif

    // ---- reset in the middle of CALC ----
    wr(ADDR_DIVIDEND, 32'h9999);
    wr(ADDR_DIVISOR, 32'd5);
    wr(ADDR_CTRL, 32'h5);                       // edge N
    tick(9);                                    // N+9
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;                         // N+10 sampled low
    check("midrst_rdata", reg_rdata, 32'h0);
    check("midrst_irq", 32'(irq), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    check_all_zero("midrst");
    tick(40);
    rd(ADDR_STATUS, v);
    check("midrst_no_done", v, 32'h0);
    rd(ADDR_QUOT, v);
    check("midrst_no_quot", v, 32'h0);
    run_op("post_rst_100_7", 32'd100, 32'd7, 32'h0);

    check("sb_empty", 32'(exp_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
